branch_resolve_unit: RTL and testbench

Parametrised, registered branch resolution stage for the execute pipeline: it evaluates the six RV32I conditional-branch compares, computes the taken target and fall-through PC, checks the front-end prediction, and raises a redirect on mispredict. It sits between the ID/EX register and the PC-select logic. It uses a valid/ready handshake with a single-entry output register, a flush input, and saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 152 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compares rs1/rs2, picks target or fall-through,
// checks the front-end prediction and holds the result in a single-entry output register.
module branch_resolve_unit #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_mispredict,
    output logic            out_misalign,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            clear_stats,
    output logic [CNTW-1:0] stat_branches,
    output logic [CNTW-1:0] stat_mispredicts
);

    // Branch op encodings follow the RV32I funct3 values.
    localparam logic [OPW-1:0] EXE_BEQ_OP  = OPW'(0);
    localparam logic [OPW-1:0] EXE_BNE_OP  = OPW'(1);
    localparam logic [OPW-1:0] EXE_BLT_OP  = OPW'(4);
    localparam logic [OPW-1:0] EXE_BGE_OP  = OPW'(5);
    localparam logic [OPW-1:0] EXE_BLTU_OP = OPW'(6);
    localparam logic [OPW-1:0] EXE_BGEU_OP = OPW'(7);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef enum logic {S_EMPTY, S_FULL} state_e;

    state_e state_q, state_d;

    logic            accept, complete;
    logic            eq, lt_s, lt_u;
    logic            res_taken, res_illegal, res_misalign, res_mispredict;
    logic [XLEN-1:0] res_target, res_fall, res_next_pc;

    logic            taken_q, mispredict_q, misalign_q, illegal_q;
    logic [XLEN-1:0] next_pc_q;
    logic [CNTW-1:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    // ---------------- combinational resolve ----------------
    assign eq   = (in_rs1 == in_rs2);
    assign lt_s = ($signed(in_rs1) < $signed(in_rs2));
    assign lt_u = (in_rs1 < in_rs2);

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (in_op)
            EXE_BEQ_OP:  res_taken = eq;
            EXE_BNE_OP:  res_taken = !eq;
            EXE_BLT_OP:  res_taken = lt_s;
            EXE_BGE_OP:  res_taken = !lt_s;
            EXE_BLTU_OP: res_taken = lt_u;
            EXE_BGEU_OP: res_taken = !lt_u;
            default:     res_illegal = 1'b1;
        endcase
    end

    assign res_target     = in_pc + in_imm;
    assign res_fall       = in_pc + XLEN'(4);
    assign res_next_pc    = res_taken ? res_target : res_fall;
    assign res_misalign   = res_taken && (res_target[1:0] != 2'b00);
    assign res_mispredict = (res_taken != in_pred_taken) || res_misalign;

    // ---------------- handshake FSM ----------------
    assign accept   = in_valid && in_ready;
    // A flushed result is dropped, never counted as completed.
    assign complete = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (flush || (complete && !accept)) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_FULL);
        in_ready  = (!out_valid || out_ready) && !flush && !rst;
    end

    // ---------------- result register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q      <= 1'b0;
            next_pc_q    <= '0;
            mispredict_q <= 1'b0;
            misalign_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (accept) begin
            taken_q      <= res_taken;
            next_pc_q    <= res_next_pc;
            mispredict_q <= res_mispredict;
            misalign_q   <= res_misalign;
            illegal_q    <= res_illegal;
        end
    end

    assign out_taken      = taken_q;
    assign out_next_pc    = next_pc_q;
    assign out_mispredict = mispredict_q;
    assign out_misalign   = misalign_q;
    assign out_illegal    = illegal_q;

    // ---------------- saturating statistics ----------------
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (clear_stats) begin
            stat_br_d = '0;
            stat_mp_d = '0;
        end else if (complete) begin
            if (stat_br_q != CNT_MAX) stat_br_d = stat_br_q + CNTW'(1);
            if (mispredict_q && (stat_mp_q != CNT_MAX)) stat_mp_d = stat_mp_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit; a CNTW=4 copy shares the stimulus
// so counter saturation is exercised alongside the default-width instance.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst, in_valid, in_pred_taken, out_ready, flush, clear_stats;
    logic [3:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm;

    logic        in_ready, out_valid, out_taken, out_mispredict, out_misalign, out_illegal;
    logic [31:0] out_next_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    logic        s_in_ready, s_out_valid, s_out_taken, s_out_mispredict, s_out_misalign, s_out_illegal;
    logic [31:0] s_out_next_pc;
    logic [3:0]  s_stat_branches, s_stat_mispredicts;

    int n_vec  = 0;
    int n_fail = 0;

    // reference state
    bit        m_valid, m_taken, m_mp, m_mal, m_ill;
    bit [31:0] m_npc;
    int        m_br, m_mpc, m_br4, m_mpc4;

    branch_resolve_unit #(.XLEN(32), .OPW(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
        .out_misalign(out_misalign), .out_illegal(out_illegal), .flush(flush),
        .clear_stats(clear_stats), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts));

    branch_resolve_unit #(.XLEN(32), .OPW(4), .CNTW(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_taken(s_out_taken), .out_next_pc(s_out_next_pc), .out_mispredict(s_out_mispredict),
        .out_misalign(s_out_misalign), .out_illegal(s_out_illegal), .flush(flush),
        .clear_stats(clear_stats), .stat_branches(s_stat_branches),
        .stat_mispredicts(s_stat_mispredicts));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    // Branch semantics straight from the ISA rules; encodings are the funct3 values.
    function automatic void ref_res(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                                    input bit [31:0] pc, input bit [31:0] imm, input bit pred,
                                    output bit t, output bit [31:0] npc, output bit mp,
                                    output bit mal, output bit ill);
        t = 0; ill = 0;
        case (op)
            4'd0: t = (a == b);
            4'd1: t = (a != b);
            4'd4: t = (int'(a) <  int'(b));
            4'd5: t = (int'(a) >= int'(b));
            4'd6: t = (a <  b);
            4'd7: t = (a >= b);
            default: ill = 1;
        endcase
        npc = t ? pc + imm : pc + 32'd4;
        mal = t && (npc % 4 != 0);
        mp  = (t != pred) || mal;
    endfunction

    // One clock: check everything at the falling edge, advance the model, then step.
    task automatic cycle();
        bit exp_rdy, acc, cmp, t, mp, mal, ill;
        bit [31:0] npc;
        @(negedge clk);
        exp_rdy = (!m_valid || out_ready) && !flush && !rst;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_valid);
        chk("out_taken", out_taken, m_taken);
        chk("out_next_pc", out_next_pc, m_npc);
        chk("out_mispredict", out_mispredict, m_mp);
        chk("out_misalign", out_misalign, m_mal);
        chk("out_illegal", out_illegal, m_ill);
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mpc);
        chk("sat_branches", s_stat_branches, m_br4);
        chk("sat_mispredicts", s_stat_mispredicts, m_mpc4);
        acc = in_valid && exp_rdy;
        cmp = m_valid && out_ready && !flush;
        ref_res(in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, t, npc, mp, mal, ill);
        if (rst) begin
            {m_valid, m_taken, m_mp, m_mal, m_ill} = '0;
            m_npc = 0; m_br = 0; m_mpc = 0; m_br4 = 0; m_mpc4 = 0;
        end else begin
            if (clear_stats) begin
                m_br = 0; m_mpc = 0; m_br4 = 0; m_mpc4 = 0;
            end else if (cmp) begin
                m_br  = (m_br  < 65535) ? m_br  + 1 : m_br;
                m_br4 = (m_br4 < 15)    ? m_br4 + 1 : m_br4;
                if (m_mp) begin
                    m_mpc  = (m_mpc  < 65535) ? m_mpc  + 1 : m_mpc;
                    m_mpc4 = (m_mpc4 < 15)    ? m_mpc4 + 1 : m_mpc4;
                end
            end
            if (acc) begin
                m_valid = 1; m_taken = t; m_npc = npc; m_mp = mp; m_mal = mal; m_ill = ill;
            end else if (flush || cmp) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                       input bit [31:0] pc, input bit [31:0] imm, input bit pred);
        in_valid = v; in_op = op; in_rs1 = a; in_rs2 = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    initial begin
        logic [31:0] held_npc;
        int          br_before, r;
        rst = 1; out_ready = 0; flush = 0; clear_stats = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
        m_valid = 0; m_taken = 0; m_npc = 0; m_mp = 0; m_mal = 0; m_ill = 0;
        m_br = 0; m_mpc = 0; m_br4 = 0; m_mpc4 = 0;
        @(posedge clk); #1;
        cycle();                               // reset-state checks, rst still high
        rst = 0; out_ready = 1;

        // signed vs unsigned
        drv(1, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1); cycle();
        chk("blt_taken", out_taken, 1); chk("blt_npc", out_next_pc, 32'h120);
        drv(1, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0); cycle();
        chk("bltu_taken", out_taken, 0); chk("bltu_npc", out_next_pc, 32'h104);
        in_valid = 0; cycle();

        // mispredict + stats, then illegal op
        clear_stats = 1; cycle(); clear_stats = 0;
        drv(1, 4'd0, 32'd5, 32'd5, 32'h200, 32'h40, 0); cycle();
        chk("beq_mp", out_mispredict, 1);
        in_valid = 0; cycle();
        chk("beq_stat_mp", stat_mispredicts, 1); chk("beq_stat_br", stat_branches, 1);
        drv(1, 4'hF, 32'd5, 32'd5, 32'h300, 32'h40, 1); cycle();
        chk("ill_flag", out_illegal, 1); chk("ill_taken", out_taken, 0);
        chk("ill_npc", out_next_pc, 32'h304);
        in_valid = 0; cycle();

        // backpressure then back-to-back
        out_ready = 0;
        drv(1, 4'd1, 32'd1, 32'd2, 32'h400, 32'h10, 1); cycle();
        held_npc = out_next_pc; br_before = m_br;
        drv(1, 4'd5, 32'd3, 32'd2, 32'h500, 32'h80, 1);
        repeat (3) cycle();
        chk("bp_hold_npc", out_next_pc, held_npc); chk("bp_hold_npc_val", held_npc, 32'h410);
        out_ready = 1; cycle();
        chk("b2b_valid", out_valid, 1); chk("b2b_npc", out_next_pc, 32'h580);
        chk("b2b_count", stat_branches, br_before + 1);

        // flush while FULL with out_ready high
        br_before = m_br; flush = 1;
        drv(1, 4'd0, 32'd7, 32'd7, 32'h600, 32'h8, 1); cycle();
        flush = 0; in_valid = 0;
        chk("flush_valid", out_valid, 0); chk("flush_count", stat_branches, br_before);
        cycle();

        // wrap and misalign
        drv(1, 4'd1, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h6, 1); cycle();
        chk("wrap_npc", out_next_pc, 32'h2); chk("wrap_mal", out_misalign, 1);
        chk("wrap_mp", out_mispredict, 1);
        drv(1, 4'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h6, 0); cycle();
        chk("wrap_nt_npc", out_next_pc, 32'h0);
        in_valid = 0; cycle();

        // saturation on the CNTW=4 copy
        clear_stats = 1; cycle(); clear_stats = 0;
        drv(1, 4'd0, 32'd1, 32'd1, 32'h700, 32'h4, 1);
        repeat (21) cycle();
        chk("sat_br15", s_stat_branches, 15); chk("sat_wide_br", stat_branches, 20);

        // clear during completion
        clear_stats = 1; cycle(); clear_stats = 0;
        chk("clear_during_cmp", stat_branches, 0);
        in_valid = 0; cycle();

        // reset mid-FULL
        out_ready = 0; drv(1, 4'd0, 32'd1, 32'd1, 32'h800, 32'h4, 0); cycle();
        in_valid = 0; rst = 1; cycle(); rst = 0;
        chk("rst_valid", out_valid, 0); chk("rst_npc", out_next_pc, 0);
        out_ready = 1;

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 99) < 8);
            clear_stats   = ($urandom_range(0, 99) < 3);
            rst           = ($urandom_range(0, 199) == 0);
            in_op         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
            in_rs1        = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3));
            in_rs2        = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
            in_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            in_imm        = {{20{r[11]}}, r[11:1], 1'b0};
            in_pred_taken = r[12];
            cycle();
        end
        rst = 0; flush = 0; clear_stats = 0; in_valid = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
